sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
- Upstream stage of the SHA-256 accelerator: takes a raw message as a stream of 32-bit big-endian words and emits padded 512-bit blocks.
- Padding per FIPS 180-4: a 0x80 byte, zero fill, then the 64-bit bit-length.
- Each block is presented with a last-block flag, ready to load into the hash core's message registers and control bits.
- Single block buffer with valid/ready handshakes on both sides.

Parameters:
- LEN_W, 64, width of the internal bit-length counter; 1..64; zero-extended into the 64-bit length field; wraps mod 2^LEN_W.

Ports:
- iClk  input  1  clock
- iReset_n  input  1  asynchronous active-low reset
- iValid  input  1  input word valid
- oReady  output  1  block accepts a word this cycle
- iData  input  32  message word; first byte in [31:24]
- iLast  input  1  word is the final word of the message
- iBytes  input  2  valid bytes in the iLast word, left-aligned; 0 means 4; ignored when iLast=0
- oBlockValid  output  1  oBlock/oLastBlock valid
- iBlockReady  input  1  downstream takes the block
- oBlock  output  512  padded block; word 0 in [511:480], word 15 in [31:0]
- oLastBlock  output  1  block is the final block of the message
- oBusy  output  1  a message is in progress (ACCEPT with idx>0, or PAD/EMIT)

Behaviour:
- Reset (async): state=ACCEPT, idx=0, len=0, oBlock=0, oBlockValid=0, oLastBlock=0, oBusy=0, pad80_done=0; oReady=1 after reset release.
- idx is a 4-bit word index into the block buffer; len is the bit count.
- ACCEPT:
  - oReady=1; word taken when iValid&oReady.
  - Word written to buf[idx]; len += 32, or 8*iBytes if iLast with iBytes!=0.
  - Partial last word (iBytes=1..3): bytes beyond iBytes forced to 0; byte 0x80 inserted at byte position iBytes; pad80_done=1.
  - idx increments.
  - Non-last word filling idx 15: go EMIT, last=0.
  - iLast: go PAD. A partial last word at idx 15 goes to EMIT(last=0) first, then PAD.
- PAD:
  - oReady=0; one word per cycle into buf[idx].
  - If !pad80_done: write 0x80000000 and set pad80_done.
  - Else if idx<14: write 0.
  - idx==14: write len[63:32] (zero-extended). idx==15: write len[31:0], then go EMIT with last=1.
  - If the 0x80 word lands at idx 14 or 15: zero-fill to 15, go EMIT with last=0, return to PAD with idx=0 (extra block).
- EMIT:
  - oBlockValid=1, oReady=0; oBlock and oLastBlock held stable until iBlockReady.
  - On handshake: oBlockValid=0 next cycle; idx=0.
  - If more padding is pending, return to PAD; if last=1, clear len and pad80_done and return to ACCEPT; otherwise return to ACCEPT.
- Latency: final word accepted at idx k → last block valid (15-k) cycles later, or 16 more cycles when an extra block is needed.
- Every message produces at least one block. A zero-byte message is not supported: an iLast word always carries ≥1 byte.
- iValid while oReady=0: ignored; the upstream holds the word.
- iBlockReady without oBlockValid: ignored.
- Reset mid-message discards the buffer and length, and drops oBlockValid immediately.

Test Plan:
- "abc": iData=0x61626300, iBytes=3, iLast at idx 0 → one block.
  - Word0=0x61626380, words1-14=0, word15=0x00000018, oLastBlock=1.
  - oBlockValid rises 15 cycles after accept.
- 55 bytes: 13 full words plus iLast word with iBytes=3 → single block.
  - Word13 ends 0x..80, word14=0, word15=0x000001B8, last=1.
- 56 bytes: 14 full words, last full (iBytes=0) → two blocks.
  - Block 1: word14=0x80000000, word15=0, last=0.
  - Block 2: words0-13=0, word15=0x000001C0, last=1.
- 64 bytes: 16 full words, iLast on the 16th → two blocks.
  - Block 1 = raw data, last=0.
  - Block 2: word0=0x80000000, word15=0x00000200, last=1.
- Backpressure: hold iBlockReady=0 for 20 cycles during EMIT → oBlock stable, oReady=0 throughout, no words lost. Release → next message accepted one cycle after the handshake.
- Async reset asserted mid-PAD → all outputs 0 immediately; a subsequent "abc" message yields the exact block from scenario 1.

Source files
------------

// File: rtl/sha256_msg_padder_if.sv
// Message word stream in, padded 512-bit block stream out.
// Both directions use a valid/ready handshake.
interface sha256_msg_padder_if;
    logic         iValid;
    logic         oReady;
    logic [31:0]  iData;
    logic         iLast;
    logic [1:0]   iBytes;
    logic         oBlockValid;
    logic         iBlockReady;
    logic [511:0] oBlock;
    logic         oLastBlock;

    modport master (
        output iValid, iData, iLast, iBytes, iBlockReady,
        input  oReady, oBlockValid, oBlock, oLastBlock
    );

    modport slave (
        input  iValid, iData, iLast, iBytes, iBlockReady,
        output oReady, oBlockValid, oBlock, oLastBlock
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: 32-bit big-endian words in,
// FIPS 180-4 padded 512-bit blocks out.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic iClk,
    input  logic iReset_n,
    sha256_msg_padder_if.slave bus,
    output logic oBusy
);
    typedef enum logic [1:0] {
        ACCEPT,
        PAD,
        EMIT
    } state_t;

    state_t       state, state_nxt;
    logic [3:0]   idx, idx_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic         pad80_done, pad80_nxt;
    logic         xtra, xtra_nxt;
    logic         pend, pend_nxt;
    logic         last_q, last_nxt;
    logic [511:0] blk;
    logic         wr_en;
    logic [31:0]  wr_word;
    logic [31:0]  part_word;
    logic [63:0]  len64;
    logic         partial;

    assign len64   = 64'(len);
    assign partial = bus.iLast && (bus.iBytes != 2'd0);

    assign bus.oReady      = (state == ACCEPT);
    assign bus.oBlockValid = (state == EMIT);
    assign bus.oBlock      = blk;
    assign bus.oLastBlock  = last_q;
    assign oBusy = (state != ACCEPT) || (idx != 4'd0);

    always_comb begin
        part_word = bus.iData;
        unique case (bus.iBytes)
            2'd1:    part_word = {bus.iData[31:24], 8'h80, 16'h0};
            2'd2:    part_word = {bus.iData[31:16], 8'h80, 8'h0};
            2'd3:    part_word = {bus.iData[31:8], 8'h80};
            default: part_word = bus.iData;
        endcase
    end

    // xtra: the 0x80 byte sits in word 14/15, so this block has no room for the length
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = len;
        pad80_nxt = pad80_done;
        xtra_nxt  = xtra;
        pend_nxt  = pend;
        last_nxt  = last_q;
        wr_en     = 1'b0;
        wr_word   = '0;
        unique case (state)
            ACCEPT: begin
                if (bus.iValid) begin
                    wr_en   = 1'b1;
                    idx_nxt = idx + 4'd1;
                    if (partial) begin
                        wr_word   = part_word;
                        len_nxt   = len + LEN_W'({bus.iBytes, 3'b000});
                        pad80_nxt = 1'b1;
                        xtra_nxt  = (idx == 4'd14);
                    end else begin
                        wr_word = bus.iData;
                        len_nxt = len + LEN_W'(32);
                    end
                    if (idx == 4'd15) begin
                        state_nxt = EMIT;
                        last_nxt  = 1'b0;
                        pend_nxt  = bus.iLast;
                        xtra_nxt  = 1'b0;
                    end else if (bus.iLast) begin
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                wr_en   = 1'b1;
                idx_nxt = idx + 4'd1;
                if (!pad80_done) begin
                    wr_word   = 32'h8000_0000;
                    pad80_nxt = 1'b1;
                    if (idx >= 4'd14) xtra_nxt = 1'b1;
                end else if (xtra || idx < 4'd14) begin
                    wr_word = '0;
                end else if (idx == 4'd14) begin
                    wr_word = len64[63:32];
                end else begin
                    wr_word = len64[31:0];
                end
                if (idx == 4'd15) begin
                    state_nxt = EMIT;
                    xtra_nxt  = 1'b0;
                    last_nxt  = pad80_done && !xtra;
                    pend_nxt  = !(pad80_done && !xtra);
                end
            end
            EMIT: begin
                if (bus.iBlockReady) begin
                    idx_nxt   = '0;
                    state_nxt = pend ? PAD : ACCEPT;
                    pend_nxt  = 1'b0;
                    last_nxt  = 1'b0;
                    if (last_q) begin
                        len_nxt   = '0;
                        pad80_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state      <= ACCEPT;
            idx        <= '0;
            len        <= '0;
            pad80_done <= 1'b0;
            xtra       <= 1'b0;
            pend       <= 1'b0;
            last_q     <= 1'b0;
            blk        <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            len        <= len_nxt;
            pad80_done <= pad80_nxt;
            xtra       <= xtra_nxt;
            pend       <= pend_nxt;
            last_q     <= last_nxt;
            if (wr_en) blk[{~idx, 5'b0} +: 32] <= wr_word;
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: vector table of message lengths
// plus backpressure and mid-message reset sequences.
module tb_sha256_msg_padder;
    logic iClk = 1'b0;
    logic iReset_n = 1'b0;
    logic oBusy;

    sha256_msg_padder_if bus();

    sha256_msg_padder #(.LEN_W(64)) dut (
        .iClk(iClk),
        .iReset_n(iReset_n),
        .bus(bus),
        .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct {
        int          nbytes;
        logic [7:0]  seed;
        int          exp_nblk;
        int          exp_lat;
        logic [31:0] exp_w15;
    } vec_t;

    vec_t vecs[9];

    logic [511:0] got_blk[4];
    logic         got_last[4];
    int           got_n;
    int           acc_c0;
    int           first_c1;
    bit           last_acc;

    localparam logic [511:0] ABC_BLK =
        {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BP2_BLK =
        {32'h11223344, 32'h80000000, 416'h0, 32'h00000020};

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Straight byte-level FIPS 180-4 padding of the generated message
    function automatic logic [511:0] model_blk(input int nbytes,
                                               input logic [7:0] seed,
                                               input int b);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] r;
        for (int j = 0; j < nbytes; j++) p.push_back(8'(seed + j));
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(nbytes) * 64'd8;
        for (int j = 7; j >= 0; j--) p.push_back(bits[8*j +: 8]);
        r = '0;
        for (int j = 0; j < 64; j++) r[511-8*j -: 8] = p[64*b+j];
        return r;
    endfunction

    task automatic run_msg(input int nbytes, input logic [7:0] seed,
                           output int lat, output bit tout);
        int nw;
        nw = (nbytes + 3) / 4;
        got_n = 0;
        first_c1 = -1;
        acc_c0 = 0;
        last_acc = 0;
        tout = 0;
        bus.iBlockReady = 1'b1;
        fork
            begin
                for (int k = 0; k < nw; k++) begin
                    logic [31:0] w;
                    for (int b = 0; b < 4; b++) begin
                        int i;
                        i = 4 * k + b;
                        w[31-8*b -: 8] = (i < nbytes) ? 8'(seed + i) : 8'hEE;
                    end
                    @(negedge iClk);
                    bus.iValid = 1'b1;
                    bus.iData  = w;
                    bus.iLast  = (k == nw - 1);
                    bus.iBytes = 2'(nbytes % 4);
                    for (int t = 0; t < 100 && !bus.oReady; t++)
                        @(negedge iClk);
                    if (k == nw - 1) acc_c0 = cyc;
                    @(posedge iClk);
                    if (k == nw - 1) last_acc = 1;
                end
                @(negedge iClk);
                bus.iValid = 1'b0;
                bus.iLast  = 1'b0;
            end
            begin
                int  t;
                bit  done;
                t = 0;
                done = 0;
                while (!done && t < 300) begin
                    @(negedge iClk);
                    t++;
                    if (bus.oBlockValid) begin
                        if (got_n < 4) begin
                            got_blk[got_n]  = bus.oBlock;
                            got_last[got_n] = bus.oLastBlock;
                        end
                        if (last_acc && first_c1 < 0) first_c1 = cyc;
                        got_n++;
                        if (bus.oLastBlock) done = 1;
                    end
                end
                if (!done) tout = 1;
            end
        join
        lat = first_c1 - (acc_c0 + 1);
    endtask

    task automatic wait_block(input string name);
        int t;
        t = 0;
        while (!bus.oBlockValid && t < 60) begin
            @(negedge iClk);
            t++;
        end
        chk(name, bus.oBlockValid, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  tout;
        bit  stable;
        logic [511:0] snap;

        vecs[0] = '{3,  8'h61, 1, 15, 32'h018};
        vecs[1] = '{55, 8'h01, 1, 2,  32'h1B8};
        vecs[2] = '{56, 8'h10, 2, 2,  32'h1C0};
        vecs[3] = '{64, 8'h20, 2, 0,  32'h200};
        vecs[4] = '{57, 8'h30, 2, 1,  32'h1C8};
        vecs[5] = '{60, 8'h40, 2, 1,  32'h1E0};
        vecs[6] = '{1,  8'h50, 1, 15, 32'h008};
        vecs[7] = '{4,  8'h70, 1, 15, 32'h020};
        vecs[8] = '{68, 8'h80, 2, 15, 32'h220};

        bus.iValid = 1'b0;
        bus.iData = '0;
        bus.iLast = 1'b0;
        bus.iBytes = '0;
        bus.iBlockReady = 1'b1;

        #1;
        chk("rst_valid", bus.oBlockValid, 1'b0);
        chk("rst_block", bus.oBlock, '0);
        chk("rst_last", bus.oLastBlock, 1'b0);
        chk("rst_busy", oBusy, 1'b0);
        repeat (3) @(negedge iClk);
        iReset_n = 1'b1;
        @(negedge iClk);
        chk("rst_ready", bus.oReady, 1'b1);

        foreach (vecs[v]) begin
            run_msg(vecs[v].nbytes, vecs[v].seed, lat, tout);
            chk($sformatf("v%0d_timeout", v), tout, 1'b0);
            chk($sformatf("v%0d_nblk", v), got_n, vecs[v].exp_nblk);
            chk($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
            for (int b = 0; b < got_n && b < 4; b++) begin
                chk($sformatf("v%0d_blk%0d", v, b), got_blk[b],
                    model_blk(vecs[v].nbytes, vecs[v].seed, b));
                chk($sformatf("v%0d_last%0d", v, b), got_last[b],
                    (b == vecs[v].exp_nblk - 1));
            end
            if (got_n > 0 && got_n <= 4)
                chk($sformatf("v%0d_w15", v), got_blk[got_n-1][31:0],
                    vecs[v].exp_w15);
            @(negedge iClk);
            chk($sformatf("v%0d_idle_busy", v), oBusy, 1'b0);
            chk($sformatf("v%0d_idle_ready", v), bus.oReady, 1'b1);
        end

        // Backpressure: block held 20 cycles while the next word waits
        @(negedge iClk);
        bus.iBlockReady = 1'b0;
        bus.iValid = 1'b1;
        bus.iData = 32'h61626300;
        bus.iLast = 1'b1;
        bus.iBytes = 2'd3;
        @(posedge iClk);
        @(negedge iClk);
        bus.iData = 32'h11223344;
        bus.iBytes = 2'd0;
        wait_block("bp_valid");
        snap = bus.oBlock;
        stable = 1;
        repeat (20) begin
            @(negedge iClk);
            if (bus.oBlock !== snap || bus.oBlockValid !== 1'b1 ||
                bus.oReady !== 1'b0)
                stable = 0;
        end
        chk("bp_stable", stable, 1'b1);
        chk("bp_block", snap, ABC_BLK);
        chk("bp_lastflag", bus.oLastBlock, 1'b1);
        bus.iBlockReady = 1'b1;
        @(negedge iClk);
        chk("bp_ready_after", bus.oReady, 1'b1);
        chk("bp_valid_drop", bus.oBlockValid, 1'b0);
        @(negedge iClk);
        bus.iValid = 1'b0;
        bus.iLast = 1'b0;
        chk("bp_busy", oBusy, 1'b1);
        wait_block("bp2_valid");
        chk("bp2_block", bus.oBlock, BP2_BLK);
        chk("bp2_last", bus.oLastBlock, 1'b1);
        @(negedge iClk);

        // Reset while padding, then a clean "abc"
        bus.iValid = 1'b1;
        bus.iData = 32'h61626300;
        bus.iLast = 1'b1;
        bus.iBytes = 2'd3;
        @(posedge iClk);
        @(negedge iClk);
        bus.iValid = 1'b0;
        bus.iLast = 1'b0;
        repeat (5) @(negedge iClk);
        chk("mid_busy", oBusy, 1'b1);
        iReset_n = 1'b0;
        #1;
        chk("mrst_valid", bus.oBlockValid, 1'b0);
        chk("mrst_block", bus.oBlock, '0);
        chk("mrst_last", bus.oLastBlock, 1'b0);
        chk("mrst_busy", oBusy, 1'b0);
        repeat (2) @(negedge iClk);
        iReset_n = 1'b1;
        run_msg(3, 8'h61, lat, tout);
        chk("post_timeout", tout, 1'b0);
        chk("post_nblk", got_n, 1);
        chk("post_block", got_blk[0], ABC_BLK);
        chk("post_lat", lat, 15);

        @(negedge iClk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
